// File: rtl/gpio_pkg.sv
// Shared GPIO constants: pin count, default synchronizer/debounce depths and
// the register indices used by both the pin driver and the input capture block.
package gpio_pkg;

  localparam int GPIO_WIDTH       = 32;
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DB_CYCLES   = 16;

  typedef enum logic [2:0] {
    GPIO_REG_DIR     = 3'd0,
    GPIO_REG_OUT     = 3'd1,
    GPIO_REG_RISE_EN = 3'd2,
    GPIO_REG_FALL_EN = 3'd3,
    GPIO_REG_MASK    = 3'd4,
    GPIO_REG_CLEAR   = 3'd5
  } gpio_reg_e;

  // Warm-up covers the synchronizer fill plus the prev register.
  function automatic int warmup_load(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/gpio_in_capture_if.sv
// CPU-side configuration/status bus of the GPIO input capture block.
interface gpio_in_capture_if #(
  parameter int WIDTH = gpio_pkg::GPIO_WIDTH
);
  logic [WIDTH-1:0] i_wdata;
  logic             i_WER;
  logic             i_WEF;
  logic             i_WEM;
  logic             i_WEC;
  logic [WIDTH-1:0] o_pending;
  logic             o_irq;

  modport master (
    output i_wdata, i_WER, i_WEF, i_WEM, i_WEC,
    input  o_pending, o_irq
  );

  modport slave (
    input  i_wdata, i_WER, i_WEF, i_WEM, i_WEC,
    output o_pending, o_irq
  );
endinterface

// File: rtl/gpio_debounce.sv
// Single-pin debouncer: output follows input only after DB_CYCLES consecutive
// cycles of disagreement; any return to the old value restarts the count.
module gpio_debounce #(
  parameter int DB_CYCLES = gpio_pkg::GPIO_DB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_dout
);

  localparam int            CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      o_dout <= 1'b0;
    end else if (i_din == o_dout) begin
      cnt <= '0;
    end else if (cnt == CNT_TC) begin
      o_dout <= i_din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronizer, per-pin edge detect, W1C pending register and
// masked interrupt. Optional per-pin debounce when GPIO_DEBOUNCE_EN is defined.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DB_CYCLES   = GPIO_DB_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_level,
  gpio_in_capture_if.slave bus
);

  localparam int            WU_LOAD = warmup_load(SYNC_STAGES);
  localparam int            WU_W    = $clog2(WU_LOAD + 1);
  localparam logic [WU_W-1:0] WU_INIT = WU_W'(WU_LOAD);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_param
    $error("gpio_in_capture: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pending;
  logic             irq;
  logic [WU_W-1:0]  warm_cnt;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_din  (sync_out[g]),
      .o_dout (o_level[g])
    );
  end
`else
  assign o_level = sync_out;
`endif

  // Edges are ignored until the pipeline holds post-reset samples, so pins
  // already high at reset do not appear as rising edges.
  always_comb begin
    rise = o_level & ~prev;
    fall = ~o_level & prev;
    evt  = '0;
    if (warm_cnt == '0) evt = (rise & rise_en) | (fall & fall_en);
    clr  = bus.i_WEC ? bus.i_wdata : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev     <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      mask     <= '0;
      pending  <= '0;
      irq      <= 1'b0;
      warm_cnt <= WU_INIT;
    end else begin
      prev <= o_level;
      if (bus.i_WER) rise_en <= bus.i_wdata;
      if (bus.i_WEF) fall_en <= bus.i_wdata;
      if (bus.i_WEM) mask    <= bus.i_wdata;
      if (warm_cnt != '0) warm_cnt <= warm_cnt - WU_W'(1);
      // A new event on a bit being cleared keeps the bit set.
      pending <= (pending & ~clr) | evt;
      irq     <= |(pending & mask);
    end
  end

  assign bus.o_pending = pending;
  assign bus.o_irq     = irq;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Scoreboard bench for gpio_in_capture: the driver queues cycle-stamped
// expectations, a negedge monitor pops and compares those due in the current cycle.
module tb_gpio_in_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pins;
  logic [31:0] level;
  int          cyc = 0;

  gpio_in_capture_if #(.WIDTH(32)) bus ();

  gpio_in_capture #(.WIDTH(32), .SYNC_STAGES(2), .DB_CYCLES(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_pins  (pins),
    .o_level (level),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_PEND = 0;
  localparam int K_IRQ  = 1;
  localparam int K_LVL  = 2;

  int          q_cyc  [$];
  int          q_kind [$];
  logic [31:0] q_exp  [$];
  logic [31:0] q_msk  [$];
  string       q_tag  [$];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mon_act;
  logic [31:0] lvl_final;

  task automatic push(input int off, input int kind, input logic [31:0] e,
                      input logic [31:0] m, input string tag);
    q_cyc.push_back(cyc + off);
    q_kind.push_back(kind);
    q_exp.push_back(e);
    q_msk.push_back(m);
    q_tag.push_back(tag);
  endtask

  task automatic exp_pend(input int off, input logic [31:0] v, input string tag);
    push(off, K_PEND, v, 32'hFFFF_FFFF, tag);
  endtask

  task automatic exp_irq(input int off, input logic v, input string tag);
    push(off, K_IRQ, {31'b0, v}, 32'h1, tag);
  endtask

  task automatic exp_lvl(input int off, input logic [31:0] v, input logic [31:0] m,
                         input string tag);
    push(off, K_LVL, v, m, tag);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobes_off();
    bus.i_WER = 1'b0;
    bus.i_WEF = 1'b0;
    bus.i_WEM = 1'b0;
    bus.i_WEC = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] == cyc) begin
        case (q_kind[i])
          K_PEND:  mon_act = bus.o_pending;
          K_IRQ:   mon_act = {31'b0, bus.o_irq};
          default: mon_act = level;
        endcase
        n_checks++;
        if ((mon_act & q_msk[i]) === (q_exp[i] & q_msk[i]))
          n_pass++;
        else
          $display("FAIL %s cyc=%0d actual=%h required=%h", q_tag[i], cyc,
                   mon_act & q_msk[i], q_exp[i] & q_msk[i]);
        q_cyc.delete(i);
        q_kind.delete(i);
        q_exp.delete(i);
        q_msk.delete(i);
        q_tag.delete(i);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.i_wdata = '0;
    strobes_off();

`ifdef GPIO_DEBOUNCE_EN
    lvl_final = 32'h4;
    pins = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    // glitch: pin 2 high for 10 cycles, then a stable 20-cycle high
    pins = 32'h4;
    for (int k = 1; k <= 28; k += 3) exp_lvl(k, 32'h0, 32'h4, "db_glitch");
    repeat (10) tick();
    pins = 32'h0;
    repeat (20) tick();
    pins = 32'h4;
    exp_lvl(17, 32'h0, 32'h4, "db_before");
    exp_lvl(18, 32'h4, 32'h4, "db_after");
    repeat (20) tick();
`else
    lvl_final = 32'hF;
    pins = 32'hFFFF_FFFF;
    // test 1: reset with pins high, all edges enabled just after reset
    tick();
    exp_pend(1, 32'h0, "rst_pend");
    exp_irq(1, 1'b0, "rst_irq");
    exp_lvl(1, 32'h0, 32'hFFFF_FFFF, "rst_lvl");
    tick();
    rst = 1'b0;
    bus.i_WER = 1'b1;
    bus.i_WEF = 1'b1;
    bus.i_wdata = 32'hFFFF_FFFF;
    exp_lvl(1, 32'h0, 32'hFFFF_FFFF, "wu_lvl_c1");
    exp_lvl(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wu_lvl_c2");
    for (int k = 1; k <= 6; k++) exp_pend(k, 32'h0, "wu_pend");
    exp_irq(6, 1'b0, "wu_irq");
    tick();
    strobes_off();

    // test 2: rise on pin 0 only, mask pin 0
    tick();
    bus.i_WER = 1'b1;
    bus.i_WEM = 1'b1;
    bus.i_wdata = 32'h1;
    tick();
    strobes_off();
    bus.i_WEF = 1'b1;
    bus.i_wdata = 32'h0;
    tick();
    strobes_off();
    tick();
    pins = 32'h0;
    for (int k = 1; k <= 6; k++) exp_pend(k, 32'h0, "t2_falls_ign");
    repeat (6) tick();
    pins = 32'h1;
    exp_pend(2, 32'h0, "t2_pend_k1");
    exp_pend(3, 32'h1, "t2_pend_k2");
    exp_irq(3, 1'b0, "t2_irq_k2");
    exp_irq(4, 1'b1, "t2_irq_k3");
    repeat (5) tick();
    bus.i_WEC = 1'b1;
    bus.i_wdata = 32'h1;
    exp_pend(1, 32'h0, "t2_clr_pend");
    exp_irq(1, 1'b1, "t2_clr_irq_lag");
    exp_irq(2, 1'b0, "t2_clr_irq");
    tick();
    strobes_off();
    tick();
    pins = 32'h0;
    for (int k = 1; k <= 6; k++) exp_pend(k, 32'h0, "t2_fall_ign");
    repeat (6) tick();

    // test 3: fall on pin 31 with mask off, then unmask
    bus.i_WEF = 1'b1;
    bus.i_wdata = 32'h8000_0000;
    tick();
    strobes_off();
    bus.i_WEM = 1'b1;
    bus.i_wdata = 32'h0;
    tick();
    strobes_off();
    pins = 32'h8000_0000;
    for (int k = 1; k <= 5; k++) exp_pend(k, 32'h0, "t3_rise31_ign");
    exp_lvl(2, 32'h8000_0000, 32'hFFFF_FFFF, "t3_lvl");
    repeat (6) tick();
    pins = 32'h0;
    exp_pend(2, 32'h0, "t3_pend_k1");
    exp_pend(3, 32'h8000_0000, "t3_pend_k2");
    exp_irq(4, 1'b0, "t3_irq_masked");
    exp_irq(5, 1'b0, "t3_irq_masked2");
    repeat (5) tick();
    bus.i_WEM = 1'b1;
    bus.i_wdata = 32'h8000_0000;
    exp_irq(1, 1'b0, "t3_irq_lag");
    exp_irq(2, 1'b1, "t3_irq_unmask");
    exp_pend(2, 32'h8000_0000, "t3_pend_keep");
    tick();
    strobes_off();
    tick();

    // test 4: set-wins on simultaneous clear and event, then plain clear
    bus.i_WEC = 1'b1;
    bus.i_wdata = 32'h8000_0000;
    exp_pend(1, 32'h0, "t4_clr31");
    exp_irq(2, 1'b0, "t4_clr31_irq");
    tick();
    strobes_off();
    bus.i_WEM = 1'b1;
    bus.i_wdata = 32'h1;
    tick();
    strobes_off();
    pins = 32'h1;
    exp_pend(3, 32'h1, "t4_set0");
    exp_irq(4, 1'b1, "t4_irq0");
    tick();
    pins = 32'h0;
    repeat (3) tick();
    pins = 32'h1;
    tick();
    tick();
    bus.i_WEC = 1'b1;
    bus.i_wdata = 32'h1;
    exp_pend(1, 32'h1, "t4_set_wins");
    tick();
    strobes_off();
    tick();
    bus.i_WEC = 1'b1;
    bus.i_wdata = 32'h1;
    exp_pend(1, 32'h0, "t4_clear");
    exp_irq(1, 1'b1, "t4_irq_lag");
    exp_irq(2, 1'b0, "t4_irq_drop");
    tick();
    strobes_off();
    tick();

    // test 5: mid-operation reset drops pending and irq
    pins = 32'h0;
    bus.i_WER = 1'b1;
    bus.i_WEM = 1'b1;
    bus.i_wdata = 32'hF;
    tick();
    strobes_off();
    repeat (3) tick();
    pins = 32'hF;
    exp_pend(3, 32'hF, "t5_pend_f");
    exp_irq(4, 1'b1, "t5_irq");
    repeat (5) tick();
    rst = 1'b1;
    exp_pend(1, 32'h0, "t5_rst_pend");
    exp_irq(1, 1'b0, "t5_rst_irq");
    exp_lvl(1, 32'h0, 32'hFFFF_FFFF, "t5_rst_lvl");
    tick();
    rst = 1'b0;
    exp_lvl(1, 32'h0, 32'hFFFF_FFFF, "t5_lvl_c1");
    exp_lvl(2, 32'hF, 32'hFFFF_FFFF, "t5_lvl_c2");
    for (int k = 1; k <= 5; k++) exp_pend(k, 32'h0, "t5_after_rst");
    exp_irq(5, 1'b0, "t5_irq_after");
    tick();
`endif

    for (int k = 0; k < 40 && q_cyc.size() != 0; k++) tick();

    n_checks++;
    if (bus.o_pending === 32'h0) n_pass++;
    else $display("FAIL final_pend actual=%h required=%h", bus.o_pending, 32'h0);
    n_checks++;
    if (bus.o_irq === 1'b0) n_pass++;
    else $display("FAIL final_irq actual=%b required=%b", bus.o_irq, 1'b0);
    n_checks++;
    if (level === lvl_final) n_pass++;
    else $display("FAIL final_lvl actual=%h required=%h", level, lvl_final);

    for (int i = 0; i < q_cyc.size(); i++)
      $display("FAIL %s timeout due_cyc=%0d actual=unchecked required=%h",
               q_tag[i], q_cyc[i], q_exp[i]);
    $display("%0d/%0d checks passed", n_pass, n_checks + q_cyc.size());
    $finish;
  end

endmodule
